mux_32x8: RTL
=============

// Module: mux_32x8
// PURPOSE
//  Transmit-side counterpart of the 8x32 byte-to-word demux.
//  - Takes one 32-bit word per handshake and serializes it onto an 8-bit lane, one byte per clk_4f cycle, MSB byte first.
//  - Sits in the PHY transmit path ahead of the serializer/lane logic; its byte stream is what the receive-side demux reassembles.
// PARAMETERS
//  DATA_W     32      input word width; must be an integer multiple of BYTE_W
//  BYTE_W     8       output lane width
//  IDLE_BYTE  8'hBC   byte driven while idle (used only with MUX_IDLE_FILL_EN)
// PORTS
//  clk_4f          in   1       byte-rate clock; all logic on posedge
//  reset_L         in   1       synchronous, active-low reset
//  data_in_32x8    in   DATA_W  word to transmit; sampled only on accept
//  valid_in_32x8   in   1       upstream offers data_in_32x8
//  ready_32x8      out  1       block can accept a word this cycle (combinational)
//  data_out_32x8   out  BYTE_W  current output byte (registered)
//  valid_out_32x8  out  1       data_out_32x8 carries a payload byte (registered)
// BEHAVIOUR
//  - Reset (reset_L==0 at posedge clk_4f):
//    - state=IDLE, byte index cnt=0, word register=0, valid_out_32x8=0.
//    - data_out_32x8=0, or IDLE_BYTE when MUX_IDLE_FILL_EN is defined.
//    - ready_32x8 is forced to 0 while reset_L==0.
//  - NBYTES=DATA_W/BYTE_W (4). Constants: cnt is 2 bits wide; cnt is the index of the byte currently on the output.
//  - ready_32x8 = reset_L && (state==IDLE || cnt==NBYTES-1).
//  - Accept = valid_in_32x8 && ready_32x8 at posedge. On accept:
//    - word register <= data_in_32x8.
//    - data_out_32x8 <= data_in_32x8[31:24]; valid_out_32x8 <= 1.
//    - cnt <= 0; state <= SEND.
//    - Latency: input word to first byte on output = 1 clk_4f.
//  - SEND, cnt<NBYTES-1:
//    - cnt <= cnt+1.
//    - data_out_32x8 <= next byte ([23:16], then [15:8], then [7:0]).
//    - valid_out_32x8 stays 1; valid_in_32x8 is ignored.
//  - SEND, cnt==NBYTES-1 (last byte on output):
//    - If accept: the new word loads as above. The stream is gapless, 4 bytes per word, with no bubble.
//    - Otherwise: state <= IDLE; valid_out_32x8 <= 0; data_out_32x8 <= 0 (or IDLE_BYTE).
//  - IDLE without valid_in_32x8: outputs hold the idle values.
//  - Upstream must hold data_in_32x8 and valid_in_32x8 until accepted. The value on data_in_32x8 at the accepting edge is the one sent.
//  - Reset mid-word: remaining bytes are dropped. Outputs take their reset values on the next edge; no partial word resumes.
//  - A 32'h0 word is legal payload: it is sent as four 8'h00 bytes with valid_out_32x8=1.
// CONFIGURATION
//  MUX_IDLE_FILL_EN
//   - Defined: whenever valid_out_32x8==0 (reset and IDLE), data_out_32x8 = IDLE_BYTE (K28.5 comma).
//   - Undefined: data_out_32x8 = 8'h00 whenever valid_out_32x8==0.
//   - valid_out_32x8 and all other timing are identical in both builds.
// STRUCTURE
//  - Shared package/include phy_pkg:
//    - state encoding: IDLE=1'b0, SEND=1'b1.
//    - COMMA_BYTE=8'hBC.
//    - NBYTES derivation.
//  - Single flat module, no sub-modules.
//  - Byte select is done with a mux on cnt; a shift register is also acceptable if the output ordering is unchanged.
// TESTING
//  1 Reset: hold reset_L=0 for 3 cycles.
//    -> valid_out=0, data_out=00 (BC with the macro), ready=0; ready=1 on the first cycle after release.
//  2 Single word: present 32'hA1B2C3D4 with valid for one accept.
//    -> output A1,B2,C3,D4 on the 4 following cycles with valid=1, then valid=0.
//  3 Back-to-back: 11223344 then 55667788, valid held high.
//    -> 8 consecutive valid bytes 11..88; ready=1 only on the D4-position cycles.
//  4 Backpressure: change data_in while ready=0.
//    -> the changes are ignored; the bytes equal the word sampled at accept.
//  5 Reset mid-word: assert reset_L=0 after byte B2 of A1B2C3D4.
//    -> next cycle valid=0; C3/D4 are never emitted.
//  6 Idle fill: build with MUX_IDLE_FILL_EN, no traffic.
//    -> data_out=8'hBC with valid=0; payload byte 8'hBC is still sent with valid=1.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY definitions: transmit FSM encoding, comma byte and bytes-per-word derivation.
// Imported by mux_32x8.
package phy_pkg;

    localparam logic [7:0] COMMA_BYTE = 8'hBC;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } phy_state_e;

    function automatic int calc_nbytes(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    localparam int NBYTES = calc_nbytes(32, 8);

endpackage

// File: rtl/mux_32x8.sv
// Word-to-byte transmit mux: serializes one DATA_W word per handshake, MSB byte first, gapless.
// Optional build macro MUX_IDLE_FILL_EN drives IDLE_BYTE instead of zero whenever no payload is on the lane.
import phy_pkg::*;

module mux_32x8 #(
    parameter int                DATA_W    = 32,
    parameter int                BYTE_W    = 8,
    parameter logic [BYTE_W-1:0] IDLE_BYTE = COMMA_BYTE
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in_32x8,
    input  logic              valid_in_32x8,
    output logic              ready_32x8,
    output logic [BYTE_W-1:0] data_out_32x8,
    output logic              valid_out_32x8
);

    localparam int               NB       = calc_nbytes(DATA_W, BYTE_W);
    localparam int               CNT_W    = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);
`ifdef MUX_IDLE_FILL_EN
    localparam logic [BYTE_W-1:0] FILL_BYTE = IDLE_BYTE;
`else
    localparam logic [BYTE_W-1:0] FILL_BYTE = {BYTE_W{1'b0}};
`endif

    phy_state_e        state_r;
    phy_state_e        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [DATA_W-1:0] word_r;
    logic [DATA_W-1:0] word_nxt_s;
    logic [DATA_W-1:0] shifted_s;
    logic [BYTE_W-1:0] data_nxt_s;
    logic              valid_nxt_s;
    logic              accept_s;

    // Handshake: a new word fits when idle or when the last byte of the current word is on the lane
    always_comb begin
        ready_32x8 = reset_L && ((state_r == IDLE) || (cnt_r == LAST_CNT));
        accept_s   = valid_in_32x8 && ready_32x8;
    end

    // Next-state, byte index and output byte selection
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        word_nxt_s  = word_r;
        data_nxt_s  = data_out_32x8;
        valid_nxt_s = valid_out_32x8;
        cnt_inc_s   = cnt_r + CNT_W'(1);
        // Bring the byte at index cnt+1 up to the top lane position
        shifted_s   = word_r << (cnt_inc_s * BYTE_W);

        if (accept_s) begin
            state_nxt_s = SEND;
            cnt_nxt_s   = {CNT_W{1'b0}};
            word_nxt_s  = data_in_32x8;
            data_nxt_s  = data_in_32x8[DATA_W-1 -: BYTE_W];
            valid_nxt_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    data_nxt_s  = FILL_BYTE;
                    valid_nxt_s = 1'b0;
                end
                SEND: begin
                    if (cnt_r != LAST_CNT) begin
                        cnt_nxt_s   = cnt_inc_s;
                        data_nxt_s  = shifted_s[DATA_W-1 -: BYTE_W];
                        valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        data_nxt_s  = FILL_BYTE;
                        valid_nxt_s = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    data_nxt_s  = FILL_BYTE;
                    valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset drops any partially sent word
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            state_r        <= IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            word_r         <= {DATA_W{1'b0}};
            data_out_32x8  <= FILL_BYTE;
            valid_out_32x8 <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            word_r         <= word_nxt_s;
            data_out_32x8  <= data_nxt_s;
            valid_out_32x8 <= valid_nxt_s;
        end
    end

endmodule
